// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared types for the ROB/RS allocation controller.
//   ROB_DEPTH      : number of ROB/RS slots (power of two, >= 4)
//   PTR_W          : slot index width
//   rob_ptr_t      : slot index (ROB number)
//   rob_cnt_t      : occupancy count, one bit wider so ROB_DEPTH is representable
//   alloc_state_e  : controller state, RUN or FLUSH
//   robAllocStruct : per-cycle A/B allocation result handed to dispatch
package rob_alloc_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PTR_W     = $clog2(ROB_DEPTH);

  typedef logic [PTR_W-1:0] rob_ptr_t;
  typedef logic [PTR_W:0]   rob_cnt_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } alloc_state_e;

  typedef struct packed {
    logic     valid_a;
    logic     valid_b;
    rob_ptr_t robnum_a;
    rob_ptr_t robnum_b;
  } robAllocStruct;

  function automatic rob_cnt_t min_cnt(input rob_cnt_t a, input rob_cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rob_alloc_ctrl_stats.sv
// Optional dispatch statistics for rob_alloc_ctrl (present only when the
// ROB_ALLOC_STATS_EN macro is defined).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   stall         : dispatch stall seen this cycle
//   occ           : registered occupancy of the ROB
//   stall_cycles  : saturating count of stalled cycles
//   peak_occ      : largest occupancy observed since reset
`ifdef ROB_ALLOC_STATS_EN
module rob_alloc_stats
  import rob_alloc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  rob_cnt_t    occ,
  output logic [31:0] stall_cycles,
  output rob_cnt_t    peak_occ
);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      peak_occ     <= '0;
    end else begin
      // Saturate instead of wrapping so a long stall storm is never hidden.
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (occ > peak_occ) begin
        peak_occ <= occ;
      end
    end
  end

endmodule
`endif

// File: rtl/rob_alloc_ctrl.sv
// ROB/reservation-station allocation controller for the 2-wide OoO core.
// Owns head (retire) and tail (allocate) pointers, assigns ROB numbers to the
// A/B dispatch slots, raises the dispatch stall and sequences flush recovery.
//
// Handshake: disp_req_a/b act as "valid" from dispatch; ~disp_stall is the
// "ready" back to dispatch. A slot transfers exactly in a cycle where its
// alloc_valid_* is 1; when disp_stall=1 dispatch must hold its register and
// present the same request again. Grants are all-or-nothing for the pair.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   disp_req_a/b         : dispatch slot requests (b ignored without a)
//   disp_stall           : combinational stall back to dispatch
//   alloc_valid_a/b      : slot granted this cycle
//   alloc_robnum_a/b     : ROB numbers tail and tail+1 (qualify with valid)
//   retire_cnt           : entries committed this cycle (0..2)
//   flush                : single-cycle flush pulse
//   occupancy            : registered count of allocated slots
//   rob_empty / rob_full : occupancy == 0 / == ROB_DEPTH
//   retire_err           : sticky, commit retired more than was allocated
//   stall_cycles         : stall counter (ROB_ALLOC_STATS_EN), else 0
//   peak_occ             : peak occupancy (ROB_ALLOC_STATS_EN), else 0
//   state_dbg            : current controller state
// Optional feature macro: ROB_ALLOC_STATS_EN
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         disp_req_a,
  input  logic         disp_req_b,
  output logic         disp_stall,
  output logic         alloc_valid_a,
  output logic         alloc_valid_b,
  output rob_ptr_t     alloc_robnum_a,
  output rob_ptr_t     alloc_robnum_b,
  input  logic [1:0]   retire_cnt,
  input  logic         flush,
  output rob_cnt_t     occupancy,
  output logic         rob_empty,
  output logic         rob_full,
  output logic         retire_err,
  output logic [31:0]  stall_cycles,
  output rob_cnt_t     peak_occ,
  output alloc_state_e state_dbg
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  alloc_state_e  state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  rob_ptr_t      head_q, head_d;
  rob_ptr_t      tail_q, tail_d;
  rob_cnt_t      occ_q, occ_d;
  logic          err_q, err_d;

  logic [1:0]    req_n;
  logic [1:0]    grant_n;
  rob_cnt_t      free_slots;
  rob_cnt_t      eff_ret;
  logic          grant;
  robAllocStruct alloc_bus;

  always_comb begin
    req_n      = {1'b0, disp_req_a} + {1'b0, disp_req_a & disp_req_b};
    // Free space comes from registered occupancy only: a retire in this
    // cycle does not make room for a grant in the same cycle.
    free_slots = rob_cnt_t'(ROB_DEPTH) - occ_q;
    eff_ret    = min_cnt(rob_cnt_t'(retire_cnt), occ_q);

    grant = 1'b0;
    if (!reset && !flush && (state_q == RUN)) begin
      grant = (rob_cnt_t'(req_n) <= free_slots);
    end
    grant_n    = grant ? req_n : 2'd0;
    disp_stall = !reset && (req_n != 2'd0) && !grant;

    alloc_bus.valid_a  = grant & disp_req_a;
    alloc_bus.valid_b  = grant & disp_req_a & disp_req_b;
    alloc_bus.robnum_a = reset ? rob_ptr_t'(0) : tail_q;
    alloc_bus.robnum_b = reset ? rob_ptr_t'(1) : tail_q + rob_ptr_t'(1);

    state_d = state_q;
    fcnt_d  = fcnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    err_d   = err_q;

    if (flush) begin
      // Flush wins over grant, retire and any FLUSH countdown in progress.
      state_d = FLUSH;
      fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          tail_d = tail_q + rob_ptr_t'(grant_n);
          head_d = head_q + eff_ret[PTR_W-1:0];
          occ_d  = occ_q + rob_cnt_t'(grant_n) - eff_ret;
          if (rob_cnt_t'(retire_cnt) > occ_q) begin
            err_d = 1'b1;
          end
        end
        FLUSH: begin
          // retire_cnt is meaningless while draining, so it is ignored here.
          if (fcnt_q == '0) begin
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - FC_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

  assign alloc_valid_a  = alloc_bus.valid_a;
  assign alloc_valid_b  = alloc_bus.valid_b;
  assign alloc_robnum_a = alloc_bus.robnum_a;
  assign alloc_robnum_b = alloc_bus.robnum_b;
  assign occupancy      = occ_q;
  assign rob_empty      = reset || (occ_q == '0);
  assign rob_full       = !reset && (occ_q == rob_cnt_t'(ROB_DEPTH));
  assign retire_err     = err_q;
  assign state_dbg      = state_q;

`ifdef ROB_ALLOC_STATS_EN
  rob_alloc_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .stall        (disp_stall),
    .occ          (occ_q),
    .stall_cycles (stall_cycles),
    .peak_occ     (peak_occ)
  );
`else
  assign stall_cycles = '0;
  assign peak_occ     = '0;
`endif

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
module tb_rob_alloc_ctrl;
  import rob_alloc_ctrl_pkg::*;

  localparam int FLUSH_CYCLES = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         disp_req_a = 1'b0, disp_req_b = 1'b0, flush = 1'b0;
  logic [1:0]   retire_cnt = 2'd0;
  logic         disp_stall, alloc_valid_a, alloc_valid_b;
  rob_ptr_t     alloc_robnum_a, alloc_robnum_b;
  rob_cnt_t     occupancy, peak_occ;
  logic         rob_empty, rob_full, retire_err;
  logic [31:0]  stall_cycles;
  alloc_state_e state_dbg;

  rob_alloc_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .disp_req_a(disp_req_a), .disp_req_b(disp_req_b), .disp_stall(disp_stall),
    .alloc_valid_a(alloc_valid_a), .alloc_valid_b(alloc_valid_b),
    .alloc_robnum_a(alloc_robnum_a), .alloc_robnum_b(alloc_robnum_b),
    .retire_cnt(retire_cnt), .flush(flush),
    .occupancy(occupancy), .rob_empty(rob_empty), .rob_full(rob_full),
    .retire_err(retire_err), .stall_cycles(stall_cycles), .peak_occ(peak_occ),
    .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: in-flight ROB numbers in allocation order.
  logic [PTR_W-1:0] exp_q[$];
  int m_tail, m_fcnt, m_stalls, m_peak;
  bit m_flushing, m_err;
  bit e_stall, e_va, e_vb;
  int e_ra, e_rb;

  task automatic model_reset();
    exp_q.delete();
    m_tail = 0; m_fcnt = 0; m_stalls = 0; m_peak = 0;
    m_flushing = 0; m_err = 0;
  endtask

  // driver: apply inputs mid-cycle and compute expected combinational outputs
  task automatic drive(input bit a, input bit b, input int ret, input bit fl);
    int req_n;
    @(negedge clk);
    disp_req_a = a; disp_req_b = b; retire_cnt = 2'(ret); flush = fl;
    req_n   = a ? (b ? 2 : 1) : 0;
    e_va    = 0; e_vb = 0;
    e_stall = (req_n != 0);
    if (!fl && !m_flushing && (req_n <= ROB_DEPTH - exp_q.size())) begin
      e_va = a; e_vb = a && b; e_stall = 0;
    end
    e_ra = m_tail;
    e_rb = (m_tail + 1) % ROB_DEPTH;
    #1;
  endtask

  // advance the model across the coming clock edge, then take the edge
  task automatic tick();
    int occ;
    int ret;
    occ = exp_q.size();
    ret = int'(retire_cnt);
    if (e_stall) m_stalls++;
    if (occ > m_peak) m_peak = occ;
    if (flush) begin
      exp_q.delete(); m_tail = 0; m_flushing = 1; m_fcnt = FLUSH_CYCLES - 1;
    end else if (m_flushing) begin
      if (m_fcnt == 0) m_flushing = 0;
      else m_fcnt--;
    end else begin
      if (ret > occ) m_err = 1;
      for (int i = 0; i < ret; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (e_va) begin exp_q.push_back(PTR_W'(m_tail)); m_tail = (m_tail + 1) % ROB_DEPTH; end
      if (e_vb) begin exp_q.push_back(PTR_W'(m_tail)); m_tail = (m_tail + 1) % ROB_DEPTH; end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; disp_req_a = 0; disp_req_b = 0; retire_cnt = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; disp_req_a = 1; disp_req_b = 1; retire_cnt = 2; flush = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (disp_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", disp_stall); end
    n_vec++; if ({alloc_valid_a, alloc_valid_b} !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b%b want 00", alloc_valid_a, alloc_valid_b); end
    n_vec++; if (alloc_robnum_a !== 4'd0 || alloc_robnum_b !== 4'd1) begin n_err++; $display("FAIL rst_robnum: got %0d,%0d want 0,1", alloc_robnum_a, alloc_robnum_b); end
    n_vec++; if (rob_empty !== 1'b1 || rob_full !== 1'b0) begin n_err++; $display("FAIL rst_flags: got empty=%b full=%b want 1,0", rob_empty, rob_full); end
    n_vec++; if (occupancy !== 5'd0 || retire_err !== 1'b0 || state_dbg !== RUN) begin n_err++; $display("FAIL rst_state: got occ=%0d err=%b st=%0d want 0,0,RUN", occupancy, retire_err, state_dbg); end
    n_vec++; if (stall_cycles !== 32'd0 || peak_occ !== 5'd0) begin n_err++; $display("FAIL rst_stats: got %0d,%0d want 0,0", stall_cycles, peak_occ); end
    disp_req_a = 0; disp_req_b = 0; retire_cnt = 0; flush = 0;
    model_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    n_vec++; if (occupancy !== 5'd0 || rob_empty !== 1'b1 || alloc_robnum_a !== 4'd0) begin n_err++; $display("FAIL post_rst: got occ=%0d empty=%b ra=%0d want 0,1,0", occupancy, rob_empty, alloc_robnum_a); end
    tick();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0);
      n_vec++;
      if ({disp_stall, alloc_valid_a, alloc_valid_b} !== 3'b011 || alloc_robnum_a !== 4'(2*i) || alloc_robnum_b !== 4'(2*i+1)) begin
        n_err++; $display("FAIL fill_%0d: got stall=%b va=%b vb=%b ra=%0d rb=%0d want 0,1,1,%0d,%0d", i, disp_stall, alloc_valid_a, alloc_valid_b, alloc_robnum_a, alloc_robnum_b, 2*i, 2*i+1);
      end
      tick();
    end
    drive(1, 1, 0, 0);
    n_vec++; if (disp_stall !== 1'b1 || alloc_valid_a !== 1'b0 || rob_full !== 1'b1 || occupancy !== 5'd16) begin n_err++; $display("FAIL fill_full: got stall=%b va=%b full=%b occ=%0d want 1,0,1,16", disp_stall, alloc_valid_a, rob_full, occupancy); end
    tick();
  endtask

  // continues from the full ROB left by test_fill
  task automatic test_full_retire();
    drive(1, 0, 1, 0);
    n_vec++; if (disp_stall !== 1'b1 || alloc_valid_a !== 1'b0) begin n_err++; $display("FAIL fullret_stall: got stall=%b va=%b want 1,0", disp_stall, alloc_valid_a); end
    tick();
    drive(1, 0, 0, 0);
    n_vec++; if (disp_stall !== 1'b0 || alloc_valid_a !== 1'b1 || alloc_robnum_a !== 4'd0) begin n_err++; $display("FAIL fullret_wrap: got stall=%b va=%b ra=%0d want 0,1,0", disp_stall, alloc_valid_a, alloc_robnum_a); end
    tick();
    drive(0, 0, 0, 0);
    n_vec++; if (occupancy !== 5'd16) begin n_err++; $display("FAIL fullret_occ: got %0d want 16", occupancy); end
    tick();
  endtask

  task automatic test_atomic();
    do_reset();
    repeat (7) begin drive(1, 1, 0, 0); tick(); end
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0);
    n_vec++; if ({disp_stall, alloc_valid_a, alloc_valid_b} !== 3'b100 || occupancy !== 5'd15) begin n_err++; $display("FAIL atomic_stall: got stall=%b va=%b vb=%b occ=%0d want 1,0,0,15", disp_stall, alloc_valid_a, alloc_valid_b, occupancy); end
    tick();
    drive(1, 0, 0, 0);
    n_vec++; if ({disp_stall, alloc_valid_a, alloc_valid_b} !== 3'b010 || alloc_robnum_a !== 4'd15) begin n_err++; $display("FAIL atomic_single: got stall=%b va=%b vb=%b ra=%0d want 0,1,0,15", disp_stall, alloc_valid_a, alloc_valid_b, alloc_robnum_a); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (7) begin drive(1, 1, 0, 0); tick(); end
    drive(1, 0, 0, 0); tick();
    repeat (6) begin drive(0, 0, 2, 0); tick(); end
    drive(0, 0, 1, 0); tick();
    drive(1, 1, 2, 0);
    n_vec++; if (occupancy !== 5'd2 || alloc_robnum_a !== 4'd15 || alloc_robnum_b !== 4'd0 || {alloc_valid_a, alloc_valid_b} !== 2'b11) begin n_err++; $display("FAIL wrap_pair: got occ=%0d ra=%0d rb=%0d v=%b%b want 2,15,0,11", occupancy, alloc_robnum_a, alloc_robnum_b, alloc_valid_a, alloc_valid_b); end
    tick();
    drive(1, 0, 0, 0);
    n_vec++; if (occupancy !== 5'd2 || alloc_robnum_a !== 4'd1) begin n_err++; $display("FAIL wrap_next: got occ=%0d ra=%0d want 2,1", occupancy, alloc_robnum_a); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    repeat (2) begin drive(1, 1, 0, 0); tick(); end
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 1);
    n_vec++; if ({disp_stall, alloc_valid_a, alloc_valid_b} !== 3'b100 || occupancy !== 5'd5) begin n_err++; $display("FAIL flush_cycle: got stall=%b va=%b vb=%b occ=%0d want 1,0,0,5", disp_stall, alloc_valid_a, alloc_valid_b, occupancy); end
    tick();
    drive(1, 1, 0, 0);
    n_vec++; if (occupancy !== 5'd0 || state_dbg !== FLUSH || disp_stall !== 1'b1) begin n_err++; $display("FAIL flush_1: got occ=%0d st=%0d stall=%b want 0,FLUSH,1", occupancy, state_dbg, disp_stall); end
    tick();
    drive(1, 1, 2, 0);
    n_vec++; if (disp_stall !== 1'b1 || alloc_valid_a !== 1'b0) begin n_err++; $display("FAIL flush_2: got stall=%b va=%b want 1,0", disp_stall, alloc_valid_a); end
    tick();
    drive(1, 1, 0, 0);
    n_vec++; if ({disp_stall, alloc_valid_a, alloc_valid_b} !== 3'b011 || alloc_robnum_a !== 4'd0 || alloc_robnum_b !== 4'd1 || retire_err !== 1'b0) begin n_err++; $display("FAIL flush_resume: got stall=%b v=%b%b ra=%0d rb=%0d err=%b want 0,11,0,1,0", disp_stall, alloc_valid_a, alloc_valid_b, alloc_robnum_a, alloc_robnum_b, retire_err); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    drive(0, 0, 0, 1); tick();
    do_reset();
    drive(1, 0, 0, 0);
    n_vec++; if (state_dbg !== RUN || alloc_valid_a !== 1'b1 || alloc_robnum_a !== 4'd0) begin n_err++; $display("FAIL rst_midflush: got st=%0d va=%b ra=%0d want RUN,1,0", state_dbg, alloc_valid_a, alloc_robnum_a); end
    tick();
  endtask

  task automatic test_retire_err();
    do_reset();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 2, 0);
    n_vec++; if (retire_err !== 1'b0 || occupancy !== 5'd1) begin n_err++; $display("FAIL reterr_pre: got err=%b occ=%0d want 0,1", retire_err, occupancy); end
    tick();
    drive(0, 0, 0, 0);
    n_vec++; if (retire_err !== 1'b1 || occupancy !== 5'd0) begin n_err++; $display("FAIL reterr_set: got err=%b occ=%0d want 1,0", retire_err, occupancy); end
    tick();
    repeat (10) begin drive(0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    n_vec++; if (retire_err !== 1'b1) begin n_err++; $display("FAIL reterr_sticky: got %b want 1", retire_err); end
    tick();
  endtask

  task automatic test_random();
    logic [18:0] act, exp;
    logic [31:0] exp_stalls;
    logic [PTR_W:0] exp_peak;
    bit a, b, fl;
    int ret;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      a   = ($urandom_range(0, 9) < 7);
      b   = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 59) == 0);
      ret = (i % 200 < 100) ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0)
                            : $urandom_range(0, 2);
      drive(a, b, ret, fl);
      exp = {e_stall, e_va, e_vb, PTR_W'(e_ra), PTR_W'(e_rb), (PTR_W+1)'(exp_q.size()),
             exp_q.size() == 0, exp_q.size() == ROB_DEPTH, m_err};
      act = {disp_stall, alloc_valid_a, alloc_valid_b, alloc_robnum_a, alloc_robnum_b,
             occupancy, rob_empty, rob_full, retire_err};
      n_vec++; if (act !== exp) begin n_err++; $display("FAIL rand_%0d: got %h want %h", i, act, exp); end
`ifdef ROB_ALLOC_STATS_EN
      exp_stalls = 32'(m_stalls);
      exp_peak   = (PTR_W+1)'(m_peak);
`else
      exp_stalls = 32'd0;
      exp_peak   = '0;
`endif
      n_vec++; if (stall_cycles !== exp_stalls || peak_occ !== exp_peak) begin n_err++; $display("FAIL rand_stats_%0d: got %0d,%0d want %0d,%0d", i, stall_cycles, peak_occ, exp_stalls, exp_peak); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_retire();
    test_atomic();
    test_wrap();
    test_flush();
    test_reset_mid_flush();
    test_retire_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Allocation controller for the shared ROB/reservation-station slot space in the 2-wide out-of-order core. It owns the tail (allocate) and head (retire) pointers and assigns ROB numbers to the A/B dispatch slots. It generates the dispatch stall when free slots are insufficient, and sequences the flush-recovery drain. It sits between decode/dispatch (which consumes alloc_robnum_a/b and obeys disp_stall) and commit (which reports retire count and flush).

Parameters:
ROB_DEPTH, 16, number of ROB/RS slots; power of two, at least 4.
PTR_W, $clog2(ROB_DEPTH), slot index width.
FLUSH_CYCLES, 2, cycles spent in the FLUSH state before returning to RUN; at least 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
disp_req_a  in  1  slot A has a valid instruction (opcode nonzero)
disp_req_b  in  1  slot B has a valid instruction; ignored unless disp_req_a=1
disp_stall  out  1  combinational; 1 = this cycle's request not granted, hold dispatch register
alloc_valid_a  out  1  slot A granted this cycle
alloc_valid_b  out  1  slot B granted this cycle
alloc_robnum_a  out  PTR_W  ROB number for slot A (= tail)
alloc_robnum_b  out  PTR_W  ROB number for slot B (= tail+1 mod ROB_DEPTH)
retire_cnt  in  2  entries committed this cycle, 0..2
flush  in  1  single-cycle mispredict/exception flush pulse
occupancy  out  PTR_W+1  registered count of allocated slots
rob_empty  out  1  occupancy==0
rob_full  out  1  occupancy==ROB_DEPTH
retire_err  out  1  sticky; retire_cnt exceeded occupancy

Behaviour:
- Reset: head=0, tail=0, occupancy=0, state=RUN, retire_err=0. Outputs during reset: disp_stall=0, alloc_valid_a/b=0, alloc_robnum_a=0, alloc_robnum_b=1, rob_empty=1, rob_full=0.
- Request count: req_n = disp_req_a + (disp_req_a & disp_req_b).
- free = ROB_DEPTH - occupancy. Uses registered occupancy only; there is no same-cycle retire bypass.
- States:
  - RUN: grant = (req_n <= free).
  - FLUSH: grant=0; disp_stall = (req_n != 0).
- Grants are atomic per pair. If two slots are requested and only one is free, both are stalled; there is no partial grant.
- alloc_valid_a = grant & disp_req_a; alloc_valid_b = grant & disp_req_a & disp_req_b. In RUN, disp_stall = (req_n != 0) & ~grant.
- alloc_robnum_a/b are driven from tail every cycle regardless of grant. They are valid only when qualified by alloc_valid.
- Next state in RUN:
  - tail += granted count, modulo ROB_DEPTH.
  - eff_ret = min(retire_cnt, occupancy); head += eff_ret, modulo ROB_DEPTH.
  - occupancy += granted count - eff_ret.
  - If retire_cnt > occupancy, retire_err <= 1 (sticky until reset).
- Simultaneous grant and retire in the same cycle: both are applied. When full with retire_cnt=2 and req_n=2, the request is still stalled, because free is taken from registered occupancy.
- flush=1 in any state has priority over everything else in that cycle:
  - No grant; disp_stall = (req_n != 0).
  - Next cycle: head=tail=0, occupancy=0, state=FLUSH, flush counter=FLUSH_CYCLES-1.
- FLUSH state: counter decrements each cycle. At counter==0, go to RUN next cycle. retire_cnt is ignored in FLUSH. A new flush in FLUSH reloads the counter.
- Reset mid-flush returns to RUN immediately with reset values.
- Pointer wrap: tail=ROB_DEPTH-1 with a 2-slot grant yields robnum_a=15, robnum_b=0, and next tail=1.

Optional Feature:
ROB_ALLOC_STATS_EN.
- Defined: adds outputs stall_cycles (32 bits, saturating count of cycles with disp_stall=1) and peak_occ (PTR_W+1 bits, maximum occupancy seen). Both clear on reset only.
- Undefined: both ports still exist and are tied to 0; no counters are synthesized.

Decomposition:
- Shared typedefs package:
  - ROB_DEPTH constant
  - rob_ptr_t (logic[PTR_W-1:0])
  - rob_cnt_t (logic[PTR_W:0])
  - alloc_state_e enum {RUN, FLUSH}
  - robAllocStruct bundling alloc_valid and robnum for A/B, for handoff to dispatch
- Sub-module: rob_alloc_stats holds the optional stall/peak counters, instantiated only under ROB_ALLOC_STATS_EN. The core pointer logic stays flat.

Test Plan:
- Reset, then 8 cycles of A+B requests with no retire → robnums (0,1),(2,3)…(14,15); cycle 9 stalls with rob_full=1 and occupancy=16.
- Full ROB, retire_cnt=1 and req_n=1 → stall that cycle. Next cycle grants robnum_a=0 (wrap) and occupancy stays 16.
- occupancy=15, A+B request → both stalled (atomic). Next cycle with A only → robnum_a=15 granted.
- tail=15, occupancy=2, A+B with retire_cnt=2 → robnums 15 and 0; next tail=1, occupancy=2.
- occupancy=5, flush plus A+B request → no grant, disp_stall=1. Next cycle occupancy=0 and state FLUSH; stalls for 2 cycles; third cycle grants robnums 0,1.
- occupancy=1, retire_cnt=2 → occupancy=0 and retire_err=1, still 1 after 10 idle cycles. With ROB_ALLOC_STATS_EN, stall_cycles matches the number of stalled cycles in the run.
